// File: rtl/sdram_wr_burst_ctrl.sv
// Drains the SDRAM write FIFO in fixed-length bursts: requests a burst at an incrementing
// word address, feeds FIFO words as the controller pulls them, and wraps over a frame region.
module sdram_wr_burst_ctrl #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 22,
    parameter int CNT_W        = 10,
    parameter int BURST_LEN    = 8,
    parameter int BASE_ADDR    = 0,
    parameter int REGION_WORDS = 307200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  fifo_usedw,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              sdram_wr_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    input  logic              sdram_wr_ack,
    input  logic              sdram_wr_data_req,
    output logic [DATA_W-1:0] sdram_wr_data,
    input  logic              sdram_wr_done,
    output logic              frame_done,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        WDONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BURST_LEN);
    // Start address of the final burst in the region; advancing from here wraps to BASE.
    localparam logic [ADDR_W-1:0] LAST_START = ADDR_W'(BASE_ADDR + REGION_WORDS - BURST_LEN);

    state_t            state_reg;
    logic [CNT_W-1:0]  beat_cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              req_reg;
    logic              frame_done_reg;
    logic              proto_err_reg;

    logic              pop;
    logic [CNT_W-1:0]  beat_cnt_next;
    logic              burst_full;
    logic              addr_wrap;
    logic [ADDR_W-1:0] addr_next;

    // Pop is suppressed while reset is held so an aborted burst leaves the FIFO untouched.
    assign pop           = !rst && (state_reg == BURST) && sdram_wr_data_req
                           && (beat_cnt_reg < BURST_CNT);
    assign beat_cnt_next = beat_cnt_reg + {{(CNT_W-1){1'b0}}, pop};
    assign burst_full    = (beat_cnt_next == BURST_CNT);
    assign addr_wrap     = (addr_reg == LAST_START);
    assign addr_next     = addr_wrap ? BASE : addr_reg + STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            beat_cnt_reg   <= '0;
            addr_reg       <= BASE;
            req_reg        <= 1'b0;
            frame_done_reg <= 1'b0;
            proto_err_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enable && (fifo_usedw >= BURST_CNT)) begin
                        req_reg   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (sdram_wr_ack) begin
                        req_reg      <= 1'b0;
                        beat_cnt_reg <= '0;
                        state_reg    <= BURST;
                    end
                end
                BURST: begin
                    beat_cnt_reg <= beat_cnt_next;
                    if (sdram_wr_done) begin
                        // Early completion still moves on so the next burst cannot overwrite this one.
                        if (!burst_full) begin
                            proto_err_reg <= 1'b1;
                        end
                        addr_reg       <= addr_next;
                        frame_done_reg <= addr_wrap;
                        state_reg      <= IDLE;
                    end else if (burst_full) begin
                        state_reg <= WDONE;
                    end
                end
                WDONE: begin
                    if (sdram_wr_data_req) begin
                        proto_err_reg <= 1'b1;
                    end
                    if (sdram_wr_done) begin
                        addr_reg       <= addr_next;
                        frame_done_reg <= addr_wrap;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign fifo_rd_en    = pop;
    assign sdram_wr_req  = req_reg;
    assign sdram_wr_addr = addr_reg;
    assign sdram_wr_data = fifo_rd_data;
    assign frame_done    = frame_done_reg;
    assign proto_err     = proto_err_reg;

endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Bench for sdram_wr_burst_ctrl: FIFO and SDRAM-controller models around the DUT, a per-cycle
// reference model of the burst protocol, directed scenarios and randomized bursts.
module tb_sdram_wr_burst_ctrl;

    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 22;
    localparam int CNT_W        = 10;
    localparam int BURST_LEN    = 8;
    localparam int BASE_ADDR    = 0;
    localparam int REGION_WORDS = 16;
    localparam int SLOTS        = REGION_WORDS / BURST_LEN;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [CNT_W-1:0]  fifo_usedw = '0;
    logic [DATA_W-1:0] fifo_rd_data = '0;
    logic              fifo_rd_en;
    logic              sdram_wr_req;
    logic [ADDR_W-1:0] sdram_wr_addr;
    logic              sdram_wr_ack = 1'b0;
    logic              sdram_wr_data_req = 1'b0;
    logic [DATA_W-1:0] sdram_wr_data;
    logic              sdram_wr_done = 1'b0;
    logic              frame_done;
    logic              proto_err;

    sdram_wr_burst_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .BURST_LEN(BURST_LEN),
        .BASE_ADDR(BASE_ADDR), .REGION_WORDS(REGION_WORDS)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .fifo_usedw(fifo_usedw), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr), .sdram_wr_ack(sdram_wr_ack),
        .sdram_wr_data_req(sdram_wr_data_req), .sdram_wr_data(sdram_wr_data),
        .sdram_wr_done(sdram_wr_done), .frame_done(frame_done), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] push_log[$];
    logic [DATA_W-1:0] popped[$];
    int  push_taken = 0;
    bit  pop_now = 1'b0;
    int  checks = 0;
    int  failures = 0;
    int  frame_cnt = 0;
    bit  stray_ack = 1'b0;
    int  drop_at = -1;

    // Reference model: phase 0 idle, 1 requesting, 2 taking data, 3 awaiting done.
    int  m_phase = 0;
    int  m_beats = 0;
    int  m_slot = 0;
    bit  m_err = 1'b0;
    bit  m_frame = 1'b0;
    bit  model_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_advance();
        m_slot  = (m_slot + 1) % SLOTS;
        m_frame = (m_slot == 0);
    endtask

    task automatic compare_proc();
        forever begin
            @(negedge clk);
            #2;
            if (model_valid) begin
                check("req", sdram_wr_req, m_phase == 1);
                check("addr", sdram_wr_addr, BASE_ADDR + m_slot * BURST_LEN);
                check("rd_en", fifo_rd_en, !rst && m_phase == 2 && sdram_wr_data_req);
                check("frame_done", frame_done, m_frame);
                check("proto_err", proto_err, m_err);
                check("wr_data", sdram_wr_data, (fifo_q.size() > 0) ? fifo_q[0] : '0);
            end
            if (frame_done === 1'b1) frame_cnt++;
            pop_now = fifo_rd_en;
            m_frame = 1'b0;
            if (rst) begin
                m_phase = 0; m_beats = 0; m_slot = 0; m_err = 1'b0; model_valid = 1'b1;
            end else begin
                case (m_phase)
                    0: if (enable && fifo_usedw >= BURST_LEN) m_phase = 1;
                    1: if (sdram_wr_ack) begin m_phase = 2; m_beats = 0; end
                    2: begin
                        if (sdram_wr_data_req) m_beats++;
                        if (sdram_wr_done) begin
                            if (m_beats < BURST_LEN) m_err = 1'b1;
                            model_advance();
                            m_phase = 0;
                        end else if (m_beats == BURST_LEN) begin
                            m_phase = 3;
                        end
                    end
                    default: begin
                        if (sdram_wr_data_req) m_err = 1'b1;
                        if (sdram_wr_done) begin model_advance(); m_phase = 0; end
                    end
                endcase
            end
        end
    endtask

    // Show-ahead FIFO: pops and writer pushes land just after the clock edge.
    task automatic fifo_proc();
        forever begin
            @(posedge clk);
            #1;
            if (pop_now && fifo_q.size() > 0) popped.push_back(fifo_q.pop_front());
            while (push_taken < push_log.size()) begin
                fifo_q.push_back(push_log[push_taken]);
                push_taken++;
            end
            fifo_usedw   = CNT_W'(fifo_q.size());
            fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        push_log.push_back(w);
    endtask

    // Controller side of one burst. mode: 0 normal, 2 done with last pop, 3 early done,
    // 4 extra data_req after the burst. gap: 0 every cycle, 1 alternating, 2 random.
    task automatic serve(input int mode, input int gap, output logic [ADDR_W-1:0] addr_seen,
                         output bit got);
        int n = 0;
        int beats = 0;
        int target;
        bit alt = 1'b1;
        got = 1'b0;
        addr_seen = '0;
        while (!sdram_wr_req && n < 40) begin
            sdram_wr_ack = stray_ack && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            n++;
        end
        sdram_wr_ack = 1'b0;
        if (!sdram_wr_req) return;
        got = 1'b1;
        addr_seen = sdram_wr_addr;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sdram_wr_ack = 1'b1;
        @(negedge clk);
        sdram_wr_ack = 1'b0;
        target = (mode == 3) ? int'($urandom_range(0, BURST_LEN - 1)) : BURST_LEN;
        while (beats < target) begin
            if (gap == 0) sdram_wr_data_req = 1'b1;
            else if (gap == 1) begin sdram_wr_data_req = alt; alt = !alt; end
            else sdram_wr_data_req = ($urandom_range(0, 1) == 1);
            if (sdram_wr_data_req) beats++;
            if (beats == drop_at) enable = 1'b0;
            sdram_wr_done = (mode == 2) && (beats == target);
            sdram_wr_ack  = stray_ack && ($urandom_range(0, 5) == 0);
            @(negedge clk);
        end
        sdram_wr_data_req = 1'b0;
        sdram_wr_done = 1'b0;
        sdram_wr_ack = 1'b0;
        if (mode != 2) begin
            if (mode == 4) begin
                sdram_wr_data_req = 1'b1;
                @(negedge clk);
                sdram_wr_data_req = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sdram_wr_done = 1'b1;
            @(negedge clk);
            sdram_wr_done = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] addrs[3];
        bit got;
        int nreq;
        int nmatch;
        int size_before;

        fork
            compare_proc();
            fifo_proc();
        join_none

        repeat (3) @(negedge clk);
        check("reset_req", sdram_wr_req, 0);
        check("reset_addr", sdram_wr_addr, BASE_ADDR);
        check("reset_rd_en", fifo_rd_en, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_proto_err", proto_err, 0);
        rst = 1'b0;

        // Single burst of a constant colour.
        enable = 1'b1;
        repeat (8) push(16'hF81F);
        serve(0, 0, a, got);
        check("t1_got_req", got, 1);
        check("t1_req_addr", a, 0);
        check("t1_next_addr", sdram_wr_addr, 8);
        check("t1_fifo_empty", fifo_q.size(), 0);
        nmatch = 0;
        foreach (popped[i]) if (popped[i] == 16'hF81F) nmatch++;
        check("t1_popped_f81f", nmatch, 8);
        popped.delete();

        // Seven words never trigger; the eighth does, one cycle after usedw shows it.
        for (int i = 0; i < 7; i++) push(DATA_W'(16'h1000 + i));
        nreq = 0;
        repeat (50) begin @(negedge clk); if (sdram_wr_req) nreq++; end
        check("t2_no_req_below_threshold", nreq, 0);
        push(16'h1007);
        @(negedge clk);
        check("t2_usedw_8", fifo_usedw, 8);
        check("t2_req_not_yet", sdram_wr_req, 0);
        @(negedge clk);
        check("t2_req_raised", sdram_wr_req, 1);
        serve(0, 1, a, got);
        check("t2_req_addr", a, 8);
        nmatch = 0;
        foreach (popped[i]) if (popped[i] == DATA_W'(16'h1000 + i)) nmatch++;
        check("t4_gapped_order", nmatch, 8);
        check("t4_gapped_count", popped.size(), 8);
        check("t2_wrap_frame_done", frame_done, 1);
        check("t2_wrap_addr", sdram_wr_addr, BASE_ADDR);
        popped.delete();

        // Three bursts over a two-burst region.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame_cnt = 0;
        for (int i = 0; i < 24; i++) push(DATA_W'($urandom));
        for (int b = 0; b < 3; b++) begin
            serve(0, 2, a, got);
            addrs[b] = a;
            @(negedge clk);
            check("t3_frame_cnt", frame_cnt, (b == 0) ? 0 : 1);
        end
        check("t3_addr0", addrs[0], 0);
        check("t3_addr1", addrs[1], 8);
        check("t3_addr2", addrs[2], 0);
        popped.delete();

        // Enable dropped mid-burst: the burst still completes, then nothing until re-enabled.
        for (int i = 0; i < 16; i++) push(DATA_W'($urandom));
        enable = 1'b1;
        drop_at = 4;
        serve(0, 0, a, got);
        drop_at = -1;
        check("t6_burst_completed", popped.size(), 8);
        nreq = 0;
        repeat (20) begin @(negedge clk); if (sdram_wr_req) nreq++; end
        check("t6_no_req_disabled", nreq, 0);
        enable = 1'b1;
        @(negedge clk);
        check("t6_req_after_enable", sdram_wr_req, 1);
        serve(0, 0, a, got);
        popped.delete();

        // Randomized legal traffic with stray acks.
        stray_ack = 1'b1;
        for (int it = 0; it < 30; it++) begin
            nreq = $urandom_range(0, 12);
            if (fifo_q.size() + nreq < 100) for (int i = 0; i < nreq; i++) push(DATA_W'($urandom));
            enable = ($urandom_range(0, 3) != 0);
            serve($urandom_range(0, 1) * 2, $urandom_range(0, 2), a, got);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        stray_ack = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        if (sdram_wr_req) serve(0, 0, a, got);
        repeat (2) @(negedge clk);

        // Reset three beats into a burst.
        size_before = fifo_q.size();
        repeat (8) push(DATA_W'($urandom));
        enable = 1'b1;
        nreq = 0;
        while (!sdram_wr_req && nreq < 40) begin @(negedge clk); nreq++; end
        check("t5_req_seen", sdram_wr_req, 1);
        sdram_wr_ack = 1'b1;
        @(negedge clk);
        sdram_wr_ack = 1'b0;
        sdram_wr_data_req = 1'b1;
        repeat (3) @(negedge clk);
        sdram_wr_data_req = 1'b0;
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("t5_req_cleared", sdram_wr_req, 0);
        check("t5_addr_base", sdram_wr_addr, BASE_ADDR);
        check("t5_rd_en_low", fifo_rd_en, 0);
        check("t5_fifo_words", fifo_q.size(), size_before + 5);
        popped.delete();

        // A ninth data request after a full burst pops nothing and flags an error.
        check("t4_err_clear", proto_err, 0);
        repeat (8) push(DATA_W'($urandom));
        enable = 1'b1;
        serve(4, 1, a, got);
        check("t4_exact_pops", popped.size(), 8);
        check("t4_proto_err", proto_err, 1);
        popped.delete();

        // Randomized traffic including protocol violations.
        stray_ack = 1'b1;
        for (int it = 0; it < 12; it++) begin
            nreq = $urandom_range(0, 12);
            if (fifo_q.size() + nreq < 100) for (int i = 0; i < nreq; i++) push(DATA_W'($urandom));
            enable = ($urandom_range(0, 3) != 0);
            serve($urandom_range(0, 4), $urandom_range(0, 2), a, got);
        end
        enable = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
